// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Two-stage issue/retire wrapper in front of the 64-bit execute ALU.
//
// Stage E holds an accepted request and drives the ALU inputs directly from
// its registers. Stage W captures the ALU's combinational result one edge
// later, resolves CBZ/CBNZ and presents the outcome downstream.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   alu_op              00 load/store, 01 CBZ, 11 CBNZ, 10 R-type
//   opcode              instruction[31:21], used only for R-type
//   operand_a/_b        request operands
//   alu_in1/_in2        registered ALU operands
//   alu_opcode          registered 4-bit ALU operation
//   alu_result/_zero    combinational ALU outputs fed back in
//   out_valid/out_ready retire handshake
//   out_result/_zero    retired ALU result and zero flag
//   out_branch_taken    CBZ/CBNZ decision
//   out_illegal         unsupported R-type opcode
// ---------------------------------------------------------------------------
module alu_issue #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [10:0]      opcode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [3:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_branch_taken,
   output logic             out_illegal
);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_ORR  = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_PASS = 4'b0111;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;

   localparam logic [1:0] KIND_ALU  = 2'd0;
   localparam logic [1:0] KIND_CBZ  = 2'd1;
   localparam logic [1:0] KIND_CBNZ = 2'd2;

   logic       e_valid;
   logic [1:0] e_kind;
   logic       e_illegal;

   logic [3:0] dec_opcode;
   logic [1:0] dec_kind;
   logic       dec_illegal;

   logic w_ready;
   logic e_advance;
   logic accept;
   logic branch_taken;

   // Translate the main-control ALUOp plus the instruction opcode field into
   // the ALU operation. Unsupported R-type opcodes still issue as an add so
   // the ALU always sees a legal code, but carry an illegal marker to retire.
   always_comb begin
      dec_opcode  = ALU_ADD;
      dec_kind    = KIND_ALU;
      dec_illegal = 1'b0;
      case (alu_op)
         2'b00: dec_opcode = ALU_ADD;
         2'b01: begin
            dec_opcode = ALU_PASS;
            dec_kind   = KIND_CBZ;
         end
         2'b11: begin
            dec_opcode = ALU_PASS;
            dec_kind   = KIND_CBNZ;
         end
         default: begin
            case (opcode)
               OPC_ADD: dec_opcode = ALU_ADD;
               OPC_SUB: dec_opcode = ALU_SUB;
               OPC_AND: dec_opcode = ALU_AND;
               OPC_ORR: dec_opcode = ALU_ORR;
               default: begin
                  dec_opcode  = ALU_ADD;
                  dec_illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

   // Handshake glue. in_ready depends only on stage occupancy and downstream
   // readiness, so a full pipe can still accept when W drains on the same edge.
   always_comb begin
      w_ready   = ~out_valid | out_ready;
      e_advance = e_valid & w_ready;
      in_ready  = ~e_valid | w_ready;
      accept    = in_valid & in_ready;
   end

   // Branch resolution uses the live ALU zero flag while the request sits in
   // E; illegal requests never report a taken branch.
   always_comb begin
      branch_taken = 1'b0;
      if (!e_illegal) begin
         branch_taken = ((e_kind == KIND_CBZ) & alu_zero) |
                        ((e_kind == KIND_CBNZ) & ~alu_zero);
      end
   end

   // Stage E: loads on accept and holds while W is stalled, which keeps the
   // ALU inputs stable. Datapath registers are left as-is when E empties.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid    <= 1'b0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_opcode <= ALU_AND;
         e_kind     <= KIND_ALU;
         e_illegal  <= 1'b0;
      end else begin
         if (accept) begin
            e_valid    <= 1'b1;
            alu_in1    <= operand_a;
            alu_in2    <= operand_b;
            alu_opcode <= dec_opcode;
            e_kind     <= dec_kind;
            e_illegal  <= dec_illegal;
         end else if (e_advance) begin
            e_valid <= 1'b0;
         end
      end
   end

   // Stage W: captures the ALU outcome when E advances and holds it until the
   // downstream consumer takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid        <= 1'b0;
         out_result       <= '0;
         out_zero         <= 1'b0;
         out_branch_taken <= 1'b0;
         out_illegal      <= 1'b0;
      end else begin
         if (e_advance) begin
            out_valid        <= 1'b1;
            out_result       <= alu_result;
            out_zero         <= alu_zero;
            out_branch_taken <= branch_taken;
            out_illegal      <= e_illegal;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
//
// Directed bench for alu_issue. A behavioural ALU drives alu_result/alu_zero
// from the DUT's ALU inputs. Every accepted request is predicted from the
// instruction semantics and queued; a negedge monitor checks the ALU inputs
// the cycle after each accept, checks each retired result in order, and
// checks that a stalled output holds still. Directed sections add literal
// expectations on the retired log.
// ---------------------------------------------------------------------------
module tb_alu_issue;

   localparam int W = 64;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
   localparam logic [10:0] OPC_BAD = 11'b11111111111;

   typedef struct packed {
      logic [W-1:0] result;
      logic         zero;
      logic         taken;
      logic         illegal;
      logic [3:0]   opc;
   } exp_t;

   typedef struct {
      logic [W-1:0] result;
      logic         zero;
      logic         taken;
      logic         illegal;
      int           cycle;
   } ret_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   alu_op;
   logic [10:0]  opcode;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic [W-1:0] alu_in1;
   logic [W-1:0] alu_in2;
   logic [3:0]   alu_opcode;
   logic [W-1:0] alu_result;
   logic         alu_zero;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_zero;
   logic         out_branch_taken;
   logic         out_illegal;

   int compared   = 0;
   int mismatched = 0;
   int cycle      = 0;

   exp_t exp_q[$];
   ret_t log_q[$];

   always #5 clk = ~clk;

   alu_issue #(.WIDTH(W)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .alu_op           (alu_op),
      .opcode           (opcode),
      .operand_a        (operand_a),
      .operand_b        (operand_b),
      .alu_in1          (alu_in1),
      .alu_in2          (alu_in2),
      .alu_opcode       (alu_opcode),
      .alu_result       (alu_result),
      .alu_zero         (alu_zero),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_result       (out_result),
      .out_zero         (out_zero),
      .out_branch_taken (out_branch_taken),
      .out_illegal      (out_illegal)
   );

   // Execute ALU standing in for the real one downstream of the wrapper.
   always_comb begin
      alu_result = '0;
      case (alu_opcode)
         4'b0000: alu_result = alu_in1 & alu_in2;
         4'b0001: alu_result = alu_in1 | alu_in2;
         4'b0010: alu_result = alu_in1 + alu_in2;
         4'b0110: alu_result = alu_in1 - alu_in2;
         4'b0111: alu_result = alu_in1;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic check_output(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // What an instruction must produce, straight from its meaning.
   function automatic exp_t predict(input logic [1:0] op, input logic [10:0] opc,
                                    input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t x;
      x.taken   = 1'b0;
      x.illegal = 1'b0;
      x.result  = a + b;
      x.opc     = 4'b0010;
      if (op == 2'b01) begin
         x.result = a;
         x.opc    = 4'b0111;
         x.taken  = (a == '0);
      end else if (op == 2'b11) begin
         x.result = a;
         x.opc    = 4'b0111;
         x.taken  = (a != '0);
      end else if (op == 2'b10) begin
         if (opc == OPC_SUB) begin
            x.result = a - b;
            x.opc    = 4'b0110;
         end else if (opc == OPC_AND) begin
            x.result = a & b;
            x.opc    = 4'b0000;
         end else if (opc == OPC_ORR) begin
            x.result = a | b;
            x.opc    = 4'b0001;
         end else if (opc != OPC_ADD) begin
            x.illegal = 1'b1;
         end
      end
      x.zero = (x.result == '0);
      return x;
   endfunction

   // Monitor: ALU-input check one cycle after each accept, in-order retire
   // check, stall-hold check, and prediction of newly accepted requests.
   logic         pend_e = 1'b0;
   exp_t         pend_x;
   logic [W-1:0] pend_a;
   logic [W-1:0] pend_b;
   logic         hold = 1'b0;
   logic [W-1:0] snap_result;
   logic         snap_zero;
   logic         snap_taken;
   logic         snap_illegal;
   exp_t         mx;
   ret_t         rx;

   always @(negedge clk) begin
      cycle++;
      if (reset) begin
         exp_q.delete();
         pend_e = 1'b0;
         hold   = 1'b0;
      end else begin
         if (pend_e) begin
            check_output("alu_opcode", alu_opcode, pend_x.opc);
            check_output("alu_in1", alu_in1, pend_a);
            check_output("alu_in2", alu_in2, pend_b);
            pend_e = 1'b0;
         end
         if (hold) begin
            check_output("hold_valid", out_valid, 1);
            check_output("hold_result", out_result, snap_result);
            check_output("hold_zero", out_zero, snap_zero);
            check_output("hold_taken", out_branch_taken, snap_taken);
            check_output("hold_illegal", out_illegal, snap_illegal);
         end
         if (out_valid) begin
            check_output("stale_valid", exp_q.size() != 0, 1);
            if (out_ready && exp_q.size() != 0) begin
               mx = exp_q.pop_front();
               check_output("out_result", out_result, mx.result);
               check_output("out_zero", out_zero, mx.zero);
               check_output("out_taken", out_branch_taken, mx.taken);
               check_output("out_illegal", out_illegal, mx.illegal);
               rx.result  = out_result;
               rx.zero    = out_zero;
               rx.taken   = out_branch_taken;
               rx.illegal = out_illegal;
               rx.cycle   = cycle;
               log_q.push_back(rx);
            end
         end
         hold         = out_valid && !out_ready;
         snap_result  = out_result;
         snap_zero    = out_zero;
         snap_taken   = out_branch_taken;
         snap_illegal = out_illegal;
         if (in_valid && in_ready) begin
            exp_q.push_back(predict(alu_op, opcode, operand_a, operand_b));
            pend_x = predict(alu_op, opcode, operand_a, operand_b);
            pend_a = operand_a;
            pend_b = operand_b;
            pend_e = 1'b1;
         end
      end
   end

   // Presents a request and leaves in_valid high once it has been taken, so
   // consecutive calls issue back-to-back.
   task automatic apply_stimulus(input logic [1:0] op, input logic [10:0] opc,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
      bit done;
      done      = 1'b0;
      alu_op    = op;
      opcode    = opc;
      operand_a = a;
      operand_b = b;
      in_valid  = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      check_output("accepted", done, 1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_log(input string name, input int idx, input logic [W-1:0] result,
                            input logic taken, input logic illegal);
      if (idx >= log_q.size()) begin
         check_output({name, "_present"}, 0, 1);
      end else begin
         check_output({name, "_result"}, log_q[idx].result, result);
         check_output({name, "_taken"}, log_q[idx].taken, taken);
         check_output({name, "_illegal"}, log_q[idx].illegal, illegal);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      alu_op    = 2'b10;
      opcode    = OPC_ADD;
      operand_a = 64'hDEAD;
      operand_b = 64'hBEEF;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;

      @(negedge clk);
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_in_ready", in_ready, 1);
      check_output("rst_alu_in1", alu_in1, 0);
      check_output("rst_alu_in2", alu_in2, 0);
      check_output("rst_alu_opcode", alu_opcode, 0);
      check_output("rst_out_result", out_result, 0);
      check_output("rst_out_zero", out_zero, 0);
      check_output("rst_out_taken", out_branch_taken, 0);
      check_output("rst_out_illegal", out_illegal, 0);

      @(posedge clk);
      #1;
      apply_stimulus(2'b10, OPC_ADD, 64'd5, 64'd7);
      in_valid = 1'b0;
      @(negedge clk);
      check_output("lat_early_valid", out_valid, 0);
      check_output("lat_alu_opcode", alu_opcode, 4'b0010);
      @(negedge clk);
      check_output("lat_valid", out_valid, 1);
      check_output("lat_result", out_result, 64'd12);
      wait_cycles(2);

      log_q.delete();
      apply_stimulus(2'b10, OPC_ADD, 64'd5, 64'd7);
      apply_stimulus(2'b10, OPC_SUB, 64'd9, 64'd9);
      apply_stimulus(2'b10, OPC_AND, 64'hF0, 64'h3C);
      apply_stimulus(2'b10, OPC_ORR, 64'hF0, 64'h0F);
      in_valid = 1'b0;
      wait_cycles(4);
      check_output("b2b_count", log_q.size(), 4);
      check_log("b2b_add", 0, 64'd12, 0, 0);
      check_log("b2b_sub", 1, 64'd0, 0, 0);
      check_log("b2b_and", 2, 64'h30, 0, 0);
      check_log("b2b_orr", 3, 64'hFF, 0, 0);
      if (log_q.size() == 4) begin
         check_output("b2b_sub_zero", log_q[1].zero, 1);
         check_output("b2b_spacing", log_q[3].cycle - log_q[0].cycle, 3);
      end

      log_q.delete();
      apply_stimulus(2'b01, 11'd0, 64'd0, 64'd9);
      apply_stimulus(2'b01, 11'd0, 64'd4, 64'd9);
      apply_stimulus(2'b11, 11'd0, 64'd4, 64'd9);
      apply_stimulus(2'b11, 11'd0, 64'd0, 64'd9);
      in_valid = 1'b0;
      wait_cycles(4);
      check_output("br_count", log_q.size(), 4);
      check_log("cbz_zero", 0, 64'd0, 1, 0);
      check_log("cbz_nonzero", 1, 64'd4, 0, 0);
      check_log("cbnz_nonzero", 2, 64'd4, 1, 0);
      check_log("cbnz_zero", 3, 64'd0, 0, 0);
      if (log_q.size() == 4) check_output("cbz_zero_flag", log_q[0].zero, 1);

      log_q.delete();
      out_ready = 1'b0;
      apply_stimulus(2'b10, OPC_ADD, 64'd1, 64'd2);
      apply_stimulus(2'b10, OPC_SUB, 64'd10, 64'd4);
      alu_op    = 2'b10;
      opcode    = OPC_ORR;
      operand_a = 64'h100;
      operand_b = 64'h1;
      in_valid  = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_output("bp_in_ready", in_ready, 0);
         check_output("bp_out_valid", out_valid, 1);
         check_output("bp_out_result", out_result, 64'd3);
         check_output("bp_alu_in1", alu_in1, 64'd10);
         check_output("bp_alu_opcode", alu_opcode, 4'b0110);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      apply_stimulus(2'b10, OPC_ORR, 64'h100, 64'h1);
      in_valid = 1'b0;
      wait_cycles(4);
      check_output("bp_count", log_q.size(), 3);
      check_log("bp_first", 0, 64'd3, 0, 0);
      check_log("bp_second", 1, 64'd6, 0, 0);
      check_log("bp_third", 2, 64'h101, 0, 0);

      log_q.delete();
      apply_stimulus(2'b10, OPC_BAD, 64'd1, 64'd2);
      apply_stimulus(2'b10, OPC_ADD, 64'h10, 64'h20);
      in_valid = 1'b0;
      wait_cycles(4);
      check_output("ill_count", log_q.size(), 2);
      check_log("ill_op", 0, 64'd3, 0, 1);
      check_log("ill_next", 1, 64'h30, 0, 0);

      out_ready = 1'b0;
      apply_stimulus(2'b10, OPC_ADD, 64'd1, 64'd1);
      apply_stimulus(2'b10, OPC_ADD, 64'd2, 64'd2);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      log_q.delete();
      repeat (5) begin
         @(negedge clk);
         check_output("mid_rst_valid", out_valid, 0);
      end
      wait_cycles(1);
      check_output("mid_rst_log", log_q.size(), 0);
      apply_stimulus(2'b00, 11'd0, 64'd3, 64'd4);
      in_valid = 1'b0;
      wait_cycles(3);
      check_output("post_rst_count", log_q.size(), 1);
      check_log("post_rst_ldst", 0, 64'd7, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage issue/retire wrapper that sits on the driving side of the 64-bit execute ALU. It accepts decoded-instruction requests over a valid/ready handshake, translates the 2-bit main-control ALUOp and the 11-bit instruction opcode field into the ALU's 4-bit operation code, and registers operands and opcode onto the ALU inputs. On the following edge it captures the ALU result and zero flag, resolves CBZ/CBNZ branch decisions, and presents the outcome downstream over a second valid/ready handshake.

## Interface
- WIDTH, 64, operand/result width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- alu_op  input  2  00 load/store, 01 CBZ, 11 CBNZ, 10 R-type
- opcode  input  11  instruction[31:21]
- operand_a  input  WIDTH  first operand (register Rn/Rt)
- operand_b  input  WIDTH  second operand (register Rm or extended immediate)
- alu_in1  output  WIDTH  registered ALU input1
- alu_in2  output  WIDTH  registered ALU input2
- alu_opcode  output  4  registered ALU OP
- alu_result  input  WIDTH  combinational ALU output
- alu_zero  input  1  combinational ALU zero flag
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_result  output  WIDTH  retired result
- out_zero  output  1  retired zero flag
- out_branch_taken  output  1  CBZ/CBNZ decision
- out_illegal  output  1  R-type opcode not supported

## Operation
- Op decode (at accept): alu_op 00 -> 0010 (add); 01 -> 0111 (pass input1), kind CBZ; 11 -> 0111, kind CBNZ; 10 -> opcode lookup: 10001011000 ADD -> 0010, 11001011000 SUB -> 0110, 10001010000 AND -> 0000, 10101010000 ORR -> 0001; any other R-type opcode -> 0010 with illegal=1.
- Only codes 0000/0001/0010/0110/0111 are ever driven on alu_opcode.
- Stage E (execute): registers e_valid, alu_in1=operand_a, alu_in2=operand_b, alu_opcode, kind (ALU/CBZ/CBNZ), illegal. ALU sees these combinationally.
- Stage W (retire): on E->W transfer captures out_result=alu_result, out_zero=alu_zero, out_illegal, out_branch_taken = (CBZ & alu_zero) | (CBNZ & ~alu_zero); 0 for non-branch kinds and for illegal.
- Flow control: w_ready = ~out_valid | out_ready; e_advance = e_valid & w_ready; in_ready = ~e_valid | w_ready (combinational, no dependence on in_valid).
- E loads on in_valid & in_ready; e_valid clears when E advances with no new accept. W loads on e_advance; out_valid clears on out_ready with no e_advance.
- Stalled stages hold all registers; alu_in1/alu_in2/alu_opcode stable while e_valid & ~w_ready.
- Datapath registers update only on load enables; they are not cleared when a stage empties.

## Timing
- Reset (sync, dominates all enables): e_valid=0, out_valid=0, alu_in1=0, alu_in2=0, alu_opcode=0000, out_result=0, out_zero=0, out_branch_taken=0, out_illegal=0; in_ready=1 in the cycle after reset.
- Latency: accept at edge N -> operands on ALU after N -> out_valid after edge N+1 (2 cycles accept-to-valid).
- Throughput: one request per cycle with out_ready held high.
- Full pipe (e_valid & out_valid & ~out_ready): in_ready=0. Same cycle out_ready=1: W drains, E advances, new request accepted, all on one edge.
- Reset mid-operation: in-flight E and W contents discarded; no out_valid after reset until a fresh accept.
- Handshake rule: outputs stable while out_valid & ~out_ready.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 -> all outputs at reset values, out_valid stays 0 until 2 cycles after first post-reset accept.
- Back-to-back R-type, out_ready=1: ADD 5+7, SUB 9-9, AND F0&3C, ORR F0|0F -> out_result 12, 0 (zero=1), 30, FF on consecutive cycles; alu_opcode 0010, 0110, 0000, 0001.
- Branches: CBZ a=0 -> taken=1, zero=1; CBZ a=4 -> taken=0; CBNZ a=4 -> taken=1; CBNZ a=0 -> taken=0; alu_opcode=0111 each.
- Backpressure: 3 requests, out_ready=0 for 4 cycles -> in_ready=0 after second accept, out_result/alu_* held stable; release -> remaining results in order, no loss/duplication.
- Illegal: alu_op=10, opcode 11111111111, a=1, b=2 -> out_illegal=1, out_result=3, taken=0; next legal op has out_illegal=0.
- Reset mid-flight: two accepted ops, reset one cycle -> out_valid=0, no stale result retired afterward.
